// File: rtl/des_round_controller.sv
// des_round_controller: runs 16 DES rounds through an external round function and owns the subkey schedule
module des_round_controller #(
   parameter int NB_ROUNDS = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        decrypt,
   input  logic [31:0] L_in,
   input  logic [31:0] R_in,
   input  logic [55:0] key_cd,
   output logic        busy,
   output logic        done,
   output logic [31:0] L_out,
   output logic [31:0] R_out,
   output logic [4:0]  round_idx,
   output logic        rf_start,
   output logic [31:0] rf_L,
   output logic [31:0] rf_R,
   output logic [47:0] rf_Kn,
   input  logic        rf_done,
   input  logic [31:0] rf_L_out,
   input  logic [31:0] rf_R_out
);
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FINISH} state_t;
   localparam logic [5:0] PC2 [48] = '{
      6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,  6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
      6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,  6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
      6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55, 6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
      6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53, 6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32};
   state_t      r_state;
   logic        r_dec;
   logic [55:0] r_cd;
   logic        r_rf_done_q;
   logic [4:0]  w_next_round;
   logic        w_two;
   logic        w_cap;
   logic [55:0] w_cd_load;
   logic [55:0] w_cd_step;
   logic [55:0] w_cd_next;
   logic [47:0] w_kn;
   function automatic logic [27:0] rot(input logic [27:0] x, input logic left, input logic two);
      return left ? (two ? {x[25:0], x[27:26]} : {x[26:0], x[27]})
                  : (two ? {x[1:0], x[27:2]}   : {x[0], x[27:1]});
   endfunction
   function automatic logic [47:0] pc2(input logic [55:0] cd);
      logic [47:0] k;
      k = '0;
      for (int i = 0; i < 48; i++) k[6'(47 - i)] = cd[6'(56 - int'(PC2[i]))];
      return k;
   endfunction
   // The schedule shifts by one at rounds 2, 9 and 16 in both directions (round 1 is handled at load).
   assign w_next_round = round_idx + 5'd1;
   assign w_two        = !(w_next_round == 5'd2 || w_next_round == 5'd9 || w_next_round == 5'd16);
   assign w_cd_load    = decrypt ? key_cd : {rot(key_cd[55:28], 1'b1, 1'b0), rot(key_cd[27:0], 1'b1, 1'b0)};
   assign w_cd_step    = {rot(r_cd[55:28], !r_dec, w_two), rot(r_cd[27:0], !r_dec, w_two)};
   assign w_cd_next    = (r_state == S_IDLE) ? w_cd_load : w_cd_step;
   assign w_kn         = pc2(w_cd_next);
   // Only a fresh rf_done edge in WAIT counts, so a level held over from the last round is not recaptured.
   assign w_cap        = (r_state == S_WAIT) && rf_done && !r_rf_done_q;
   // Round sequencer: every transition into ISSUE also registers the operands and the start pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_dec       <= 1'b0;
         r_cd        <= '0;
         r_rf_done_q <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         L_out       <= '0;
         R_out       <= '0;
         round_idx   <= '0;
         rf_start    <= 1'b0;
         rf_L        <= '0;
         rf_R        <= '0;
         rf_Kn       <= '0;
      end else begin
         r_rf_done_q <= rf_done;
         rf_start    <= 1'b0;
         done        <= 1'b0;
         case (r_state)
            S_IDLE: if (start) begin
               r_dec     <= decrypt;
               r_cd      <= w_cd_next;
               rf_L      <= L_in;
               rf_R      <= R_in;
               rf_Kn     <= w_kn;
               round_idx <= 5'd1;
               busy      <= 1'b1;
               rf_start  <= 1'b1;
               r_state   <= S_ISSUE;
            end
            S_ISSUE: r_state <= S_WAIT;
            S_WAIT: if (w_cap) begin
               rf_L <= rf_L_out;
               rf_R <= rf_R_out;
               if (round_idx == 5'(NB_ROUNDS)) begin
                  L_out   <= rf_R_out;
                  R_out   <= rf_L_out;
                  done    <= 1'b1;
                  r_state <= S_FINISH;
               end else begin
                  round_idx <= w_next_round;
                  r_cd      <= w_cd_next;
                  rf_Kn     <= w_kn;
                  rf_start  <= 1'b1;
                  r_state   <= S_ISSUE;
               end
            end
            S_FINISH: begin
               busy      <= 1'b0;
               round_idx <= '0;
               r_state   <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_des_round_controller.sv
// tb_des_round_controller: drives the round controller with a DES round-function stub and checks against a DES model
module tb_des_round_controller;
   localparam int SB [8][64] = '{
      '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
        4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
      '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
        0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
      '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
        13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
      '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
        10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
      '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
        4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
      '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
        9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
      '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
        1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
      '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
        7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};
   localparam int PT [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                              2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
   localparam int PC2T [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                                41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
   localparam logic [55:0] FK = 56'hF0CCAAF556678F;
   logic        clk = 1'b0, rst = 1'b1, start = 1'b0, decrypt = 1'b0;
   logic [31:0] L_in = '0, R_in = '0;
   logic [55:0] key_cd = '0;
   logic        busy, done, rf_start, rf_done;
   logic [31:0] L_out, R_out, rf_L, rf_R;
   logic [31:0] rf_L_out = '0, rf_R_out = '0;
   logic [4:0]  round_idx;
   logic [47:0] rf_Kn;
   int checks = 0, errors = 0, cyc = 0, t0 = 0, done_cyc = 0, n_done = 0;
   int stub_d = 1, stub_h = 1, s_cnt = 0, s_hold = 0;
   bit s_pend = 1'b0;
   logic [31:0] s_l = '0, s_r = '0;
   logic [47:0] s_k = '0;
   logic [47:0] kn_q[$];

   des_round_controller dut (
      .clk(clk), .rst(rst), .start(start), .decrypt(decrypt), .L_in(L_in), .R_in(R_in), .key_cd(key_cd),
      .busy(busy), .done(done), .L_out(L_out), .R_out(R_out), .round_idx(round_idx),
      .rf_start(rf_start), .rf_L(rf_L), .rf_R(rf_R), .rf_Kn(rf_Kn),
      .rf_done(rf_done), .rf_L_out(rf_L_out), .rf_R_out(rf_R_out));

   always #5 clk = ~clk;
   // Cycle index used for latency measurement.
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] des_f(input logic [31:0] r, input logic [47:0] k);
      logic [47:0] x;
      logic [31:0] s, p;
      logic [5:0] b;
      for (int i = 0; i < 48; i++) x[47-i] = r[31-((4*(i/6) + (i%6) + 31) % 32)];
      x = x ^ k;
      for (int g = 0; g < 8; g++) begin
         b = x[47-6*g -: 6];
         s[31-4*g -: 4] = 4'(SB[g][int'({b[5], b[0]})*16 + int'(b[4:1])]);
      end
      for (int i = 0; i < 32; i++) p[31-i] = s[32-PT[i]];
      return p;
   endfunction

   function automatic logic [27:0] rotl28(input logic [27:0] x, input int t);
      return (x << t) | (x >> (28 - t));
   endfunction

   // Subkey n is PC-2 of C0/D0 rotated by the cumulative DES shift count.
   function automatic logic [47:0] subkey(input logic [55:0] k, input int n);
      int t;
      logic [55:0] cd;
      logic [47:0] o;
      t = 0;
      for (int m = 1; m <= n; m++) t += (m == 1 || m == 2 || m == 9 || m == 16) ? 1 : 2;
      t = t % 28;
      cd = {rotl28(k[55:28], t), rotl28(k[27:0], t)};
      for (int i = 0; i < 48; i++) o[47-i] = cd[56-PC2T[i]];
      return o;
   endfunction

   function automatic logic [63:0] model(input logic [55:0] k, input logic [31:0] l, r, input bit dec);
      logic [31:0] tmp;
      for (int n = 1; n <= 16; n++) begin
         tmp = r;
         r = l ^ des_f(r, subkey(k, dec ? 17 - n : n));
         l = tmp;
      end
      return {r, l};
   endfunction

   // Round-function stub: result appears D cycles after rf_start and rf_done stays high for H cycles.
   always @(posedge clk) begin
      if (s_hold > 0) s_hold <= s_hold - 1;
      if (rf_start) begin
         if (stub_d == 1) begin
            s_pend   <= 1'b0;
            s_hold   <= stub_h;
            rf_L_out <= rf_R;
            rf_R_out <= rf_L ^ des_f(rf_R, rf_Kn);
         end else begin
            s_pend <= 1'b1;
            s_cnt  <= 1;
            s_l    <= rf_L;
            s_r    <= rf_R;
            s_k    <= rf_Kn;
         end
      end else if (s_pend) begin
         s_cnt <= s_cnt + 1;
         if (s_cnt + 1 == stub_d) begin
            s_pend   <= 1'b0;
            s_hold   <= stub_h;
            rf_L_out <= s_r;
            rf_R_out <= s_l ^ des_f(s_r, s_k);
         end
      end
   end
   assign rf_done = (s_hold != 0);

   // Monitor: records every issued subkey and every done pulse.
   always @(negedge clk) begin
      if (rf_start === 1'b1) kn_q.push_back(rf_Kn);
      if (done === 1'b1) begin
         n_done++;
         done_cyc = cyc;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic start_block(input logic [55:0] k, input logic [31:0] l, r, input bit dec, input int d, h);
      stub_d = d;
      stub_h = h;
      kn_q.delete();
      n_done = 0;
      @(negedge clk);
      key_cd = k; L_in = l; R_in = r; decrypt = dec; start = 1'b1; t0 = cyc;
      @(negedge clk);
      start = 1'b0;
      key_cd = {24'($urandom), $urandom}; L_in = $urandom; R_in = $urandom; decrypt = ~dec;
   endtask

   task automatic wait_done(input bit poke, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 2000 && !ok; i++) begin
         @(negedge clk);
         ok = (done === 1'b1);
      end
      if (ok && poke) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic check_block(input string tag, input logic [55:0] k, input logic [31:0] l, r,
                              input bit dec, input int d, input bit poke);
      bit ok;
      int bad;
      wait_done(poke, ok);
      chk({tag, "_timeout"}, 64'(ok), 64'd1);
      chk({tag, "_latency"}, 64'(done_cyc - t0), 64'(16 * (1 + d) + 1));
      chk({tag, "_nstart"}, 64'(kn_q.size()), 64'd16);
      chk({tag, "_ndone"}, 64'(n_done), 64'd1);
      chk({tag, "_out"}, {L_out, R_out}, model(k, l, r, dec));
      bad = 0;
      foreach (kn_q[i]) if (kn_q[i] !== subkey(k, dec ? 16 - i : i + 1)) bad++;
      chk({tag, "_keys"}, 64'(bad), 64'd0);
   endtask

   initial begin
      bit ok;
      logic [55:0] k;
      logic [31:0] l, r;
      logic [63:0] ct;
      bit dec;
      int d;
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_rfstart", 64'(rf_start), 64'd0);
      chk("rst_round", 64'(round_idx), 64'd0);
      chk("rst_out", {L_out, R_out}, 64'd0);
      chk("rst_rf", {rf_L, rf_R}, 64'd0);
      chk("rst_kn", 64'(rf_Kn), 64'd0);
      rst = 1'b0;

      start_block(FK, 32'hCC00CCFF, 32'hF0AAF0AA, 1'b0, 1, 1);
      chk("s1_busy", 64'(busy), 64'd1);
      chk("s1_round1", 64'(round_idx), 64'd1);
      chk("s1_kn1", 64'(rf_Kn), 64'h1B02EFFC7072);
      check_block("s1", FK, 32'hCC00CCFF, 32'hF0AAF0AA, 1'b0, 1, 1'b1);
      chk("s1_lastkn", 64'(kn_q.size() > 0 ? kn_q[kn_q.size() - 1] : 48'h0), 64'hCB3D8B0E17F5);
      chk("s1_fips", {L_out, R_out}, 64'h0A4CD99543423234);
      chk("finish_start_busy", 64'(busy), 64'd0);
      chk("finish_start_round", 64'(round_idx), 64'd0);
      repeat (3) @(negedge clk);
      chk("finish_start_nstart", 64'(kn_q.size()), 64'd16);
      chk("hold_out", {L_out, R_out}, 64'h0A4CD99543423234);

      start_block(FK, 32'h0A4CD995, 32'h43423234, 1'b1, 1, 1);
      chk("s2_kn1", 64'(rf_Kn), 64'hCB3D8B0E17F5);
      check_block("s2", FK, 32'h0A4CD995, 32'h43423234, 1'b1, 1, 1'b0);
      chk("s2_fips", {L_out, R_out}, 64'hCC00CCFFF0AAF0AA);

      start_block(FK, 32'hCC00CCFF, 32'hF0AAF0AA, 1'b0, 3, 1);
      check_block("s3_d3", FK, 32'hCC00CCFF, 32'hF0AAF0AA, 1'b0, 3, 1'b0);

      start_block(FK, 32'hCC00CCFF, 32'hF0AAF0AA, 1'b0, 2, 1);
      ok = 1'b0;
      for (int i = 0; i < 500 && !ok; i++) begin
         @(negedge clk);
         ok = (round_idx == 5'd5);
      end
      chk("s4_reach5", 64'(ok), 64'd1);
      start = 1'b1; decrypt = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_block("s4", FK, 32'hCC00CCFF, 32'hF0AAF0AA, 1'b0, 2, 1'b0);
      chk("s4_fips", {L_out, R_out}, 64'h0A4CD99543423234);

      start_block(FK, 32'h12345678, 32'h9ABCDEF0, 1'b0, 3, 1);
      ok = 1'b0;
      for (int i = 0; i < 500 && !ok; i++) begin
         @(negedge clk);
         ok = (round_idx == 5'd8);
      end
      chk("s5_reach8", 64'(ok), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("s5_busy", 64'(busy), 64'd0);
      chk("s5_rfstart", 64'(rf_start), 64'd0);
      chk("s5_round", 64'(round_idx), 64'd0);
      chk("s5_out", {L_out, R_out}, 64'd0);
      repeat (40) @(negedge clk);
      chk("s5_nodone", 64'(n_done), 64'd0);
      chk("s5_idle", 64'(busy), 64'd0);
      start_block(FK, 32'hCC00CCFF, 32'hF0AAF0AA, 1'b0, 1, 1);
      check_block("s5_again", FK, 32'hCC00CCFF, 32'hF0AAF0AA, 1'b0, 1, 1'b0);
      chk("s5_fips", {L_out, R_out}, 64'h0A4CD99543423234);

      start_block(FK, 32'hCC00CCFF, 32'hF0AAF0AA, 1'b0, 3, 3);
      check_block("s6_hold", FK, 32'hCC00CCFF, 32'hF0AAF0AA, 1'b0, 3, 1'b0);
      chk("s6_fips", {L_out, R_out}, 64'h0A4CD99543423234);

      for (int n = 0; n < 6; n++) begin
         k = {24'($urandom), $urandom};
         l = $urandom;
         r = $urandom;
         dec = 1'($urandom_range(0, 1));
         d = $urandom_range(1, 4);
         start_block(k, l, r, dec, d, 1);
         check_block($sformatf("rnd%0d", n), k, l, r, dec, d, 1'b0);
      end

      k = {24'($urandom), $urandom};
      l = $urandom;
      r = $urandom;
      start_block(k, l, r, 1'b0, 2, 1);
      check_block("rt_enc", k, l, r, 1'b0, 2, 1'b0);
      ct = {L_out, R_out};
      start_block(k, ct[63:32], ct[31:0], 1'b1, 2, 1);
      check_block("rt_dec", k, ct[63:32], ct[31:0], 1'b1, 2, 1'b0);
      chk("rt_plain", {L_out, R_out}, {l, r});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
